// File: rtl/test_32.sv
// test_32: 16 x 8 read-only memory with a one-clock registered read.
// Ports: i_clk, i_rst (async, active-high), i_en, i_addr -> o_data, o_valid.
module test_32 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] data_q;
    logic              valid_d;
    logic              valid_q;
    logic [DATA_W-1:0] rom_word;

    // Constant contents: word n holds {n, ~n}.
    always_comb begin
        rom_word = '0;
        case (i_addr)
            4'd0:    rom_word = 8'h0F;
            4'd1:    rom_word = 8'h1E;
            4'd2:    rom_word = 8'h2D;
            4'd3:    rom_word = 8'h3C;
            4'd4:    rom_word = 8'h4B;
            4'd5:    rom_word = 8'h5A;
            4'd6:    rom_word = 8'h69;
            4'd7:    rom_word = 8'h78;
            4'd8:    rom_word = 8'h87;
            4'd9:    rom_word = 8'h96;
            4'd10:   rom_word = 8'hA5;
            4'd11:   rom_word = 8'hB4;
            4'd12:   rom_word = 8'hC3;
            4'd13:   rom_word = 8'hD2;
            4'd14:   rom_word = 8'hE1;
            4'd15:   rom_word = 8'hF0;
            default: rom_word = '0;
        endcase
    end

    // An idle edge clears the output word rather than holding it.
    always_comb begin
        data_d  = '0;
        valid_d = 1'b0;
        if (i_en) begin
            data_d  = rom_word;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule

// File: tb/tb_test_32.sv
// tb_test_32: directed and randomized checks of test_32 against
// an arithmetic model of the ROM contents.
module tb_test_32;

    logic       i_clk;
    logic       i_rst;
    logic       i_en;
    logic [3:0] i_addr;
    logic [7:0] o_data;
    logic       o_valid;

    int tests_run;
    int tests_failed;

    test_32 dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .i_addr (i_addr),
        .o_data (o_data),
        .o_valid(o_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Word n = n*16 + (15-n); idle edges give zero.
    function automatic logic [7:0] model_data(input logic en,
                                              input int a);
        int v;
        v = en ? (a * 16 + (15 - a)) : 0;
        return v[7:0];
    endfunction

    task automatic check(input string tag,
                         input logic [7:0] obs_d,
                         input logic [7:0] exp_d,
                         input logic obs_v,
                         input logic exp_v);
        tests_run++;
        assert (obs_d === exp_d && obs_v === exp_v)
        else begin
            tests_failed++;
            $error("FAIL %s: observed data=%h valid=%b expected data=%h valid=%b",
                   tag, obs_d, obs_v, exp_d, exp_v);
        end
    endtask

    // Drive at negedge, check 1 time unit after the rising edge.
    task automatic step(input string tag, input logic en,
                        input int a);
        @(negedge i_clk);
        i_en   = en;
        i_addr = 4'(a);
        @(posedge i_clk);
        #1;
        check(tag, o_data, model_data(en, a), o_valid, en);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        i_rst  = 1'b1;
        i_en   = 1'b1;
        i_addr = 4'd5;
        #1;
        check("reset_no_clk", o_data, 8'h00, o_valid, 1'b0);

        @(posedge i_clk);
        #1;
        check("reset_held_clk", o_data, 8'h00, o_valid, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step("first_after_reset", 1'b1, 5);
        check("first_is_5a", o_data, 8'h5A, o_valid, 1'b1);

        for (int a = 0; a < 16; a++)
            step($sformatf("sweep_%0d", a), 1'b1, a);
        check("sweep_end_f0", o_data, 8'hF0, o_valid, 1'b1);

        step("gate_10", 1'b1, 10);
        step("gate_off_11", 1'b0, 11);
        step("gate_off_12", 1'b0, 12);
        step("gate_off_13", 1'b0, 13);
        step("gate_14", 1'b1, 14);

        for (int a = 0; a < 4; a++)
            step($sformatf("pre_rst_%0d", a), 1'b1, a);
        check("mid_is_3c", o_data, 8'h3C, o_valid, 1'b1);
        #1;
        i_rst = 1'b1;
        #1;
        check("async_reset", o_data, 8'h00, o_valid, 1'b0);
        @(negedge i_clk);
        i_en   = 1'b1;
        i_addr = 4'd4;
        @(posedge i_clk);
        #1;
        check("reset_held_en", o_data, 8'h00, o_valid, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        step("post_reset_4", 1'b1, 4);

        step("wrap_15", 1'b1, 15);
        step("wrap_0", 1'b1, 0);
        check("wrap_0f", o_data, 8'h0F, o_valid, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            logic en;
            int   a;
            en = 1'($urandom_range(0, 1));
            a  = int'($urandom_range(0, 15));
            step("random", en, a);
        end

        $display("[TB] %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/test_32.md
TEST_32 -- requirements
Module: test_32

Interface
REQ-001 Parameter ADDR_W, default 4, address width; only the default is supported, because the contents table is defined for 16 words.
REQ-002 Parameter DATA_W, default 8, data width; only the default is supported.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_en  input  1  read enable, sampled on rising i_clk.
REQ-006 i_addr  input  4  word address 0..15, sampled on rising i_clk.
REQ-007 o_data  output  8  registered read data.
REQ-008 o_valid  output  1  registered flag; high when o_data holds a word read on the previous enabled edge.

Function
REQ-009 The block SHALL be a read-only memory of 16 words x 8 bits; no write path exists.
REQ-010 Word n (n = 0..15) SHALL have contents {n[3:0], ~n[3:0]}.
REQ-011 Examples of REQ-010: addr0=8'h0F, addr1=8'h1E, addr2=8'h2D, addr5=8'h5A, addr10=8'hA5, addr14=8'hE1, addr15=8'hF0.
REQ-012 Contents SHALL be a constant table in logic, not loaded from a file.
REQ-013 On a rising i_clk with i_en=1, o_data SHALL take ROM[i_addr] and o_valid SHALL go 1; read latency is exactly one clock.
REQ-014 On a rising i_clk with i_en=0, o_data SHALL go to 8'h00 and o_valid SHALL go to 0.
REQ-015 Consecutive enabled cycles SHALL each produce a new word; a new address can be accepted every clock.
REQ-016 i_addr changes while i_en=0 SHALL have no effect on outputs.
REQ-017 Address 15 followed by address 0 SHALL read normally; there is no special wrap behaviour.
REQ-018 Outputs SHALL depend only on registered state, with no combinational path from inputs to outputs.
REQ-019 X or Z on i_addr while i_en=1 is a usage error, and output content is not specified for that cycle.

Reset
REQ-020 When i_rst is asserted, o_data SHALL go to 8'h00 and o_valid SHALL go to 0 immediately, without waiting for a clock edge.
REQ-021 While i_rst=1, outputs SHALL hold reset values regardless of i_en or i_clk.
REQ-022 Reset asserted in the middle of a read sequence SHALL discard the pending read.
REQ-023 The first rising i_clk after i_rst deasserts SHALL behave per REQ-013/REQ-014.

Verification
REQ-024 Reset and idle: assert i_rst with i_en=1 and i_addr=5, no clocks -> o_data=8'h00 and o_valid=0; release reset, clock once -> o_data=8'h5A and o_valid=1.
REQ-025 Full sweep: i_en=1, i_addr=0..15, one address per clock -> o_data sequence 0F,1E,2D,3C,4B,5A,69,78,87,96,A5,B4,C3,D2,E1,F0, each one clock after its address, with o_valid=1 throughout.
REQ-026 Enable gating: i_en=1 at addr 10, then i_en=0 for 3 clocks while i_addr walks 11..13, then i_en=1 at addr 14 -> o_data A5, 00, 00, 00, E1, and o_valid 1,0,0,0,1.
REQ-027 Async reset mid-sweep: assert i_rst between clock edges while o_data=8'h3C -> o_data=8'h00 and o_valid=0 before the next edge.
REQ-028 Wrap: i_en=1, addresses 15 then 0 -> o_data F0 then 0F.
REQ-029 Scoreboard: random addresses with random i_en over 1000 clocks -> each output compared against REQ-010/REQ-014 with one-clock delay and zero mismatches.
